controle_acumulador: RTL and testbench
======================================

# controle_acumulador

Sequencing controller that sits directly upstream of the 16-bit accumulator datapath. On a start request it clears the accumulator, then reads a block of consecutive words from a synchronous memory. Each word is strobed into the accumulator's B register with `Load` and added into A with `Transfer`. It signals completion with a one-cycle `Done` pulse, after which the accumulator output holds the sum of the block, modulo 2^16.

## Interface
- `ADDR_WIDTH`, 4, memory address width; the block can address 2^ADDR_WIDTH words.
- `Clock`  in  1  single system clock; all state updates on the rising edge.
- `ResetN`  in  1  reset, asynchronous and active-low.
- `Start`  in  1  request to sum a block; sampled only in IDLE.
- `BaseAddr`  in  ADDR_WIDTH  first word address; latched when Start is accepted.
- `Count`  in  ADDR_WIDTH+1  number of words to sum, 0..2^(ADDR_WIDTH+1)-1; latched when Start is accepted.
- `MemAddr`  out  ADDR_WIDTH  memory read address.
- `MemRead`  out  1  memory read enable. Data is valid on the memory output the cycle after.
- `Clear`  out  1  clear strobe to the accumulator A register.
- `Load`  out  1  load strobe to the accumulator B register; memory data goes to `DataIN`.
- `Transfer`  out  1  add strobe: A <= A + B on this edge.
- `Busy`  out  1  high from Start acceptance until the cycle before Done.
- `Done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, CLEAR, READ, LOAD, ADD, DONE.
- IDLE
  - All strobes low.
  - If Start=1: latch BaseAddr into the address counter and Count into the remaining counter, then go to CLEAR.
- CLEAR
  - Clear=1 for exactly one cycle.
  - Next state: READ if remaining≠0, otherwise DONE.
- READ
  - MemRead=1 and MemAddr = address counter.
  - Next state: LOAD.
- LOAD
  - Load=1; memory data is valid in this cycle and is captured into B.
  - Next state: ADD.
- ADD
  - Transfer=1.
  - Address counter increments by 1, wrapping modulo 2^ADDR_WIDTH.
  - Remaining counter decrements by 1.
  - Next state: READ if the decremented remaining≠0, otherwise DONE.
- DONE
  - Done=1 for one cycle.
  - Next state: IDLE.
- Clear, Load and Transfer are mutually exclusive; at most one is high in any cycle.
- MemAddr is registered. It holds its last value outside READ and is 0 after reset.
- Start while Busy=1 or in DONE is ignored and not queued.
- Counts larger than 2^ADDR_WIDTH re-read wrapped addresses; this is defined behaviour, not an error.
- Accumulator carry-out is discarded; the sum is modulo 2^16. The controller does not observe data.

## Timing
- Reset (ResetN=0, asynchronous)
  - State goes to IDLE; both counters go to 0.
  - All outputs go to 0: MemAddr=0, MemRead=0, Clear=0, Load=0, Transfer=0, Busy=0, Done=0.
  - Reset asserted mid-operation aborts immediately; no Done is produced.
  - The first Start is sampled at the first rising edge after ResetN rises.
- Cycle numbering: cycle 1 is the cycle after the edge that samples Start.
  - Cycle 1 is CLEAR.
  - Word k (k = 0..Count-1) occupies READ in cycle 2+3k, LOAD in 3+3k, ADD in 4+3k.
  - Done is high in cycle 2+3·Count; total latency is 2+3·Count cycles.
- Busy is high in cycles 1 .. 1+3·Count and low in the Done cycle.
- Start held high continuously is accepted in the cycle after DONE, i.e. the first IDLE cycle.
- Every output is driven directly from registers or from the state, with no combinational path from inputs.
- Memory read latency is fixed at one cycle.

## Test plan
- Basic sum:
  - Stimulus: mem[2..5] = 0x0001, 0x0002, 0x0003, 0x0004; BaseAddr=2; Count=4; pulse Start.
  - Required: Clear in cycle 1; MemAddr 2, 3, 4, 5 in cycles 2, 5, 8, 11; Done in cycle 14; accumulator DataOut=0x000A.
- Zero count:
  - Stimulus: Count=0.
  - Required: Clear in cycle 1, Done in cycle 2; no MemRead, Load or Transfer; DataOut=0x0000.
- Wrap and overflow:
  - Stimulus: ADDR_WIDTH=4; BaseAddr=14; Count=3; mem[14]=0xFFFF, mem[15]=0x0002, mem[0]=0x0010.
  - Required: MemAddr sequence 14, 15, 0; DataOut=0x0011.
- Busy rejection:
  - Stimulus: Start pulse in cycle 4 of a Count=2 run.
  - Required: ignored; exactly one Done, in cycle 8; Busy never drops early.
- Reset mid-operation:
  - Stimulus: ResetN low in cycle 6 of a Count=4 run.
  - Required: all outputs 0 immediately (asynchronous); no Done; a new Start after release runs a full fresh sequence starting with Clear.
- Strobe exclusivity:
  - Stimulus: random BaseAddr and Count over 200 runs.
  - Required: the bench checks that no cycle has two of Clear/Load/Transfer high, and that DataOut matches a reference sum modulo 2^16.

Source files
------------

// File: rtl/controle_acumulador.sv
// Sequencer that clears a 16-bit accumulator, then reads a block of memory words
// and strobes each one through B into A. Ends with a one-cycle Done pulse.
//
// state | meaning
// IDLE  | waiting for Start; all strobes low
// CLEAR | Clear strobe to accumulator A
// READ  | MemRead with MemAddr = current word address
// LOAD  | memory data valid, Load strobe captures it into B
// ADD   | Transfer strobe (A <= A + B), advance address, count down
// DONE  | one-cycle Done pulse
module controle_acumulador #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic [ADDR_WIDTH:0]   Count,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemRead,
  output logic                  Clear,
  output logic                  Load,
  output logic                  Transfer,
  output logic                  Busy,
  output logic                  Done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    READ  = 3'd2,
    LOAD  = 3'd3,
    ADD   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ZERO = '0;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH-1:0] addr_next;

  assign addr_next = addr_cnt + ADDR_ONE;

  // Outputs are registered together with the state they belong to, so every
  // output changes on the same edge as the state that asserts it.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      remaining <= '0;
      MemAddr   <= '0;
      MemRead   <= 1'b0;
      Clear     <= 1'b0;
      Load      <= 1'b0;
      Transfer  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            addr_cnt  <= BaseAddr;
            remaining <= Count;
            Clear     <= 1'b1;
            Busy      <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          Clear <= 1'b0;
          if (remaining != REM_ZERO) begin
            MemRead <= 1'b1;
            MemAddr <= addr_cnt;
            state   <= READ;
          end else begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        READ: begin
          MemRead <= 1'b0;
          Load    <= 1'b1;
          state   <= LOAD;
        end
        LOAD: begin
          Load     <= 1'b0;
          Transfer <= 1'b1;
          state    <= ADD;
        end
        ADD: begin
          Transfer  <= 1'b0;
          addr_cnt  <= addr_next;
          remaining <= remaining - REM_ONE;
          // remaining still holds the pre-decrement value here
          if (remaining != REM_ONE) begin
            MemRead <= 1'b1;
            MemAddr <= addr_next;
            state   <= READ;
          end else begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          MemRead  <= 1'b0;
          Clear    <= 1'b0;
          Load     <= 1'b0;
          Transfer <= 1'b0;
          Busy     <= 1'b0;
          Done     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_acumulador.sv
// Self-checking bench for controle_acumulador: models the synchronous memory and
// the 16-bit accumulator, and checks every output cycle by cycle against the timing.
module tb_controle_acumulador;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        Start;
  logic [3:0]  BaseAddr;
  logic [4:0]  Count;
  logic [3:0]  MemAddr;
  logic        MemRead, Clear, Load, Transfer, Busy, Done;

  logic [15:0] mem [16];
  logic [15:0] mem_q;
  logic [15:0] acc_a, acc_b;
  logic [3:0]  last_addr;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [3:0]  base;
    logic [4:0]  count;
    logic [15:0] sum;
    int          lat;
    int          start_at;
  } vec_t;

  vec_t vecs [8];

  controle_acumulador #(.ADDR_WIDTH(4)) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .Start    (Start),
    .BaseAddr (BaseAddr),
    .Count    (Count),
    .MemAddr  (MemAddr),
    .MemRead  (MemRead),
    .Clear    (Clear),
    .Load     (Load),
    .Transfer (Transfer),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clock = ~Clock;

  // Synchronous memory, one-cycle read latency
  always @(posedge Clock) if (MemRead) mem_q <= mem[MemAddr];

  // Accumulator datapath driven by the controller strobes
  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      acc_a <= '0;
      acc_b <= '0;
    end else if (Clear) acc_a <= '0;
    else if (Load) acc_b <= mem_q;
    else if (Transfer) acc_a <= acc_a + acc_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {MemAddr, MemRead, Clear, Load, Transfer, Busy, Done};
  endfunction

  // Starts one block and checks every cycle up to the first IDLE cycle after Done.
  task automatic run_block(input vec_t v, input string tag);
    int body_end;
    logic e_read, e_load, e_xfer, e_clear, e_busy, e_done;
    body_end = 1 + 3 * int'(v.count);
    @(negedge Clock);
    BaseAddr = v.base;
    Count    = v.count;
    Start    = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    for (int c = 1; c <= v.lat + 1; c++) begin
      e_clear = (c == 1);
      e_read  = (c >= 2) && (c <= body_end) && ((c - 2) % 3 == 0);
      e_load  = (c >= 3) && (c <= body_end) && ((c - 3) % 3 == 0);
      e_xfer  = (c >= 4) && (c <= body_end) && ((c - 4) % 3 == 0);
      e_busy  = (c <= body_end);
      e_done  = (c == v.lat);
      if (e_read) last_addr = v.base + 4'((c - 2) / 3);
      check($sformatf("%s outs c%0d", tag, c), {22'd0, outs()},
            {22'd0, last_addr, e_read, e_clear, e_load, e_xfer, e_busy, e_done});
      check($sformatf("%s excl c%0d", tag, c), 32'($countones({Clear, Load, Transfer}) <= 1), 32'd1);
      if (c == v.lat) check($sformatf("%s sum", tag), {16'd0, acc_a}, {16'd0, v.sum});
      Start = (c == v.start_at);
      @(negedge Clock);
    end
    Start = 1'b0;
  endtask

  initial begin
    vec_t rv;
    Start = 0; BaseAddr = '0; Count = '0; mem_q = '0; last_addr = '0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h0010; mem[1]  = 16'h1000;
    mem[2]  = 16'h0001; mem[3]  = 16'h0002; mem[4] = 16'h0003; mem[5] = 16'h0004;
    mem[6]  = 16'h8000; mem[7]  = 16'h8000; mem[8] = 16'h0005;
    mem[14] = 16'hFFFF; mem[15] = 16'h0002;

    // {base, count, sum mod 2^16, Done cycle, cycle of a stray Start (0 = none)}
    vecs[0] = '{4'd2,  5'd4,  16'h000A, 14, 0};  // basic sum
    vecs[1] = '{4'd0,  5'd0,  16'h0000, 2,  0};  // zero count
    vecs[2] = '{4'd14, 5'd3,  16'h0011, 11, 0};  // address wrap + overflow
    vecs[3] = '{4'd2,  5'd2,  16'h0003, 8,  4};  // Start while busy ignored
    vecs[4] = '{4'd6,  5'd2,  16'h0000, 8,  0};  // 0x8000+0x8000 wraps to 0
    vecs[5] = '{4'd15, 5'd2,  16'h0012, 8,  0};  // 15 -> 0
    vecs[6] = '{4'd8,  5'd1,  16'h0005, 5,  0};  // single word
    vecs[7] = '{4'd0,  5'd17, 16'h1030, 53, 0};  // count beyond 16 re-reads word 0

    ResetN = 1'b0;
    #12;
    check("reset outs", {22'd0, outs()}, 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;

    for (int i = 0; i < 8; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    // Reset in cycle 6 of a Count=4 run aborts at once
    @(negedge Clock);
    BaseAddr = 4'd2; Count = 5'd4; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (5) begin
      check("pre-reset no done", {31'd0, Done}, 32'd0);
      @(negedge Clock);
    end
    check("pre-reset busy", {31'd0, Busy}, 32'd1);
    #1 ResetN = 1'b0;
    #1 check("async reset outs", {22'd0, outs()}, 32'd0);
    repeat (2) @(negedge Clock);
    check("held reset outs", {22'd0, outs()}, 32'd0);
    ResetN = 1'b1;
    last_addr = '0;
    run_block(vecs[0], "post-reset");

    // Random blocks against a reference sum
    for (int r = 0; r < 200; r++) begin
      rv.base = 4'($urandom_range(0, 15));
      rv.count = 5'($urandom_range(0, 31));
      rv.sum = '0;
      for (int k = 0; k < int'(rv.count); k++) rv.sum = rv.sum + mem[4'(int'(rv.base) + k)];
      rv.lat = 2 + 3 * int'(rv.count);
      rv.start_at = 0;
      run_block(rv, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
